// File: rtl/dsp_mac_pkg.sv
// Shared constants and helpers for the dsp_mac_engine MAC pipeline:
// MODE bit positions, signed saturation and add-overflow detection.
package dsp_mac_pkg;

    localparam int MODE_PRE_EN  = 0;
    localparam int MODE_PRE_SUB = 1;
    localparam int MODE_BIAS_EN = 2;

    // Clamp a 64-bit signed value to the range of a w-bit signed number (w <= 63).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // Two's-complement add overflows when both operands share a sign the sum lacks.
    function automatic logic add_ovf(input logic a_sign,
                                     input logic b_sign,
                                     input logic sum_sign);
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

endpackage

// File: rtl/dsp_mac_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed clamp of the
// final accumulator value. ACC_W must stay below 63.
module dsp_mac_round_sat
    import dsp_mac_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] P,
    output logic                    clipped
);

    // Half an output LSB; collapses to zero when SHIFT is 0.
    localparam logic signed [ACC_W:0] RND = ((ACC_W + 1)'(1) << SHIFT) >> 1;

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;
    logic signed [63:0]    r_ext;

    // One guard bit keeps the rounding add from wrapping.
    assign sum     = {acc[ACC_W-1], acc} + RND;
    assign r       = sum >>> SHIFT;
    assign r_ext   = 64'(r);
    assign P       = OUT_W'(sat_signed(r_ext, OUT_W));
    assign clipped = (64'(P) != r_ext);

endmodule

// File: rtl/dsp_mac_engine.sv
// Pipelined, stallable signed multiply-accumulate engine: pre-adder, multiply,
// frame accumulate with optional bias, then round/saturate into a ready/valid result.
module dsp_mac_engine
    import dsp_mac_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int C_W   = 48,
    parameter int ACC_W = 48,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0,
    parameter int MREG  = 1,
    parameter int CNT_W = 10
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    IN_LAST,
    input  logic signed [A_W-1:0]   A,
    input  logic signed [B_W-1:0]   B,
    input  logic signed [B_W-1:0]   D,
    input  logic signed [C_W-1:0]   C,
    input  logic        [2:0]       MODE,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [OUT_W-1:0] P,
    output logic        [CNT_W-1:0] TERMS,
    output logic                    OVF
);

    localparam int PROD_W = A_W + B_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic stall;

    logic signed [B_W:0]       mul_b_d;
    logic                      s1_valid_q, s1_last_q, s1_bias_q;
    logic signed [A_W-1:0]     s1_a_q;
    logic signed [B_W:0]       s1_mulb_q;
    logic signed [C_W-1:0]     s1_c_q;

    logic signed [PROD_W-1:0]  prod_d;
    logic                      s2_valid, s2_last, s2_bias;
    logic signed [PROD_W-1:0]  s2_prod;
    logic signed [C_W-1:0]     s2_c;

    logic signed [ACC_W-1:0]   acc_q, acc_d, base, prod_ext, c_ext, sum1, sum2;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic                      ovf_acc_q, ovf_acc_d, first_q, first_d;
    logic                      o1, o2, add_bias;
    logic                      s3_valid_q, s3_last_q;

    logic signed [OUT_W-1:0]   rs_p;
    logic                      rs_clipped;
    logic                      load_out;
    logic                      out_valid_q, ovf_q;
    logic signed [OUT_W-1:0]   p_q;
    logic        [CNT_W-1:0]   terms_q;

    assign stall    = out_valid_q & ~OUT_READY;
    assign IN_READY = ~stall;

    // S1: pre-adder at B_W+1 bits so D+B / D-B never wrap.
    always_comb begin
        mul_b_d = {B[B_W-1], B};
        if (MODE[MODE_PRE_EN]) begin
            mul_b_d = MODE[MODE_PRE_SUB] ? ({D[B_W-1], D} - {B[B_W-1], B})
                                         : ({D[B_W-1], D} + {B[B_W-1], B});
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bias_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_mulb_q  <= '0;
            s1_c_q     <= '0;
        end else if (!stall) begin
            s1_valid_q <= IN_VALID;
            s1_last_q  <= IN_LAST;
            s1_bias_q  <= MODE[MODE_BIAS_EN];
            s1_a_q     <= A;
            s1_mulb_q  <= mul_b_d;
            s1_c_q     <= C;
        end
    end

    // S2: multiply, optionally registered.
    assign prod_d = PROD_W'(s1_a_q) * PROD_W'(s1_mulb_q);

    if (MREG != 0) begin : g_mreg
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                s2_valid <= 1'b0;
                s2_last  <= 1'b0;
                s2_bias  <= 1'b0;
                s2_prod  <= '0;
                s2_c     <= '0;
            end else if (!stall) begin
                s2_valid <= s1_valid_q;
                s2_last  <= s1_last_q;
                s2_bias  <= s1_bias_q;
                s2_prod  <= prod_d;
                s2_c     <= s1_c_q;
            end
        end
    end else begin : g_mcomb
        assign s2_valid = s1_valid_q;
        assign s2_last  = s1_last_q;
        assign s2_bias  = s1_bias_q;
        assign s2_prod  = prod_d;
        assign s2_c     = s1_c_q;
    end

    // S3: accumulate. A zero base on the first term makes acc = prod with no overflow.
    assign prod_ext = ACC_W'(s2_prod);
    assign c_ext    = ACC_W'(s2_c);
    assign base     = first_q ? '0 : acc_q;
    assign sum1     = base + prod_ext;
    assign sum2     = sum1 + c_ext;
    assign add_bias = s2_last & s2_bias;
    assign o1       = add_ovf(base[ACC_W-1], prod_ext[ACC_W-1], sum1[ACC_W-1]);
    assign o2       = add_ovf(sum1[ACC_W-1], c_ext[ACC_W-1], sum2[ACC_W-1]);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        first_d   = first_q;
        if (!stall && s2_valid) begin
            acc_d     = add_bias ? sum2 : sum1;
            ovf_acc_d = (ovf_acc_q & ~first_q) | o1 | (add_bias & o2);
            cnt_d     = first_q ? CNT_W'(1)
                                : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
            first_d   = s2_last;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            first_q    <= 1'b1;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            first_q   <= first_d;
            if (!stall) begin
                s3_valid_q <= s2_valid;
                s3_last_q  <= s2_last;
            end
        end
    end

    dsp_mac_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc     (acc_q),
        .P       (rs_p),
        .clipped (rs_clipped)
    );

    // S4: only a completed frame loads; a consumed result is replaced without a gap.
    assign load_out = ~stall & s3_valid_q & s3_last_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            terms_q     <= '0;
            ovf_q       <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            p_q         <= rs_p;
            terms_q     <= cnt_q;
            ovf_q       <= ovf_acc_q | rs_clipped;
        end else if (OUT_READY) begin
            out_valid_q <= 1'b0;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign TERMS     = terms_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Self-checking bench for dsp_mac_engine: directed scenarios plus randomized frames
// checked against an arithmetic frame model, on a 32-bit/no-shift and an 8-bit/shift-4 instance.
module tb_dsp_mac_engine;

    typedef struct {
        longint p;
        int     terms;
        bit     ovf;
    } exp_t;

    localparam longint ACC_MAX = (longint'(1) <<< 47) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< 47);

    logic clk, rst_n;
    logic in_valid, in_last, out_ready;
    logic signed [17:0] a, b, d;
    logic signed [47:0] c;
    logic [2:0] mode;

    logic in_ready, out_valid, ovf;
    logic signed [31:0] p;
    logic [9:0] terms;
    logic in_ready8, out_valid8, ovf8;
    logic signed [7:0] p8;
    logic [9:0] terms8;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    exp_t q0[$];
    exp_t q8[$];

    bit     m_first = 1;
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 0;

    dsp_mac_engine #(.OUT_W(32), .SHIFT(0)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_LAST(in_last), .A(a), .B(b), .D(d), .C(c), .MODE(mode),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .P(p), .TERMS(terms), .OVF(ovf)
    );

    dsp_mac_engine #(.OUT_W(8), .SHIFT(4)) dut8 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready8),
        .IN_LAST(in_last), .A(a), .B(b), .D(d), .C(c), .MODE(mode),
        .OUT_VALID(out_valid8), .OUT_READY(out_ready), .P(p8), .TERMS(terms8), .OVF(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- reference model ----------------
    function automatic longint add48(longint x, longint y);
        longint s;
        s = x + y;
        if (s > ACC_MAX || s < ACC_MIN) m_ovf = 1;
        return (s <<< 16) >>> 16;
    endfunction

    function automatic exp_t model_out(longint acc, int shift, int outw);
        exp_t   e;
        longint r, hi, lo;
        r  = (acc + ((longint'(1) <<< shift) >>> 1)) >>> shift;
        hi = (longint'(1) <<< (outw - 1)) - 1;
        lo = -(longint'(1) <<< (outw - 1));
        e.p     = (r > hi) ? hi : ((r < lo) ? lo : r);
        e.ovf   = m_ovf | (e.p != r);
        e.terms = (m_cnt > 1023) ? 1023 : m_cnt;
        return e;
    endfunction

    function automatic void model_accept(longint av, longint bv, longint dv, longint cv,
                                         logic [2:0] md, bit lst);
        longint mb, prod;
        mb   = md[0] ? (md[1] ? dv - bv : dv + bv) : bv;
        prod = av * mb;
        if (m_first) begin
            m_acc = prod;
            m_cnt = 1;
            m_ovf = 0;
        end else begin
            m_acc = add48(m_acc, prod);
            m_cnt++;
        end
        if (lst && md[2]) m_acc = add48(m_acc, cv);
        if (lst) begin
            q0.push_back(model_out(m_acc, 0, 32));
            q8.push_back(model_out(m_acc, 4, 8));
        end
        m_first = lst;
    endfunction

    // ---------------- result monitors ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL mon32_unexpected: got P=%0d TERMS=%0d, required no result", p, terms);
            end else begin
                e = q0.pop_front();
                if (longint'(p) !== e.p || 32'(terms) !== e.terms || ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL mon32_result: got P=%0d TERMS=%0d OVF=%0b, required P=%0d TERMS=%0d OVF=%0b",
                             p, terms, ovf, e.p, e.terms, e.ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready) begin
            exp_t e;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL mon8_unexpected: got P=%0d TERMS=%0d, required no result", p8, terms8);
            end else begin
                e = q8.pop_front();
                if (longint'(p8) !== e.p || 32'(terms8) !== e.terms || ovf8 !== e.ovf) begin
                    errors++;
                    $display("FAIL mon8_result: got P=%0d TERMS=%0d OVF=%0b, required P=%0d TERMS=%0d OVF=%0b",
                             p8, terms8, ovf8, e.p, e.terms, e.ovf);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Offer one term and hold it until accepted; returns at posedge+1 after the transfer.
    task automatic send(input longint av, input longint bv, input longint dv, input longint cv,
                        input logic [2:0] md, input bit lst);
        bit ok;
        ok = 0;
        a = 18'(av); b = 18'(bv); d = 18'(dv); c = 48'(cv); mode = md; in_last = lst;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready && in_ready8) begin
                ok = 1;
                model_accept(av, bv, dv, cv, md, lst);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got IN_READY=0 for 300 cycles, required acceptance");
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || p !== 32'sd0 || terms !== 10'd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got OV=%0b P=%0d TERMS=%0d OVF=%0b IR=%0b, required 0 0 0 0 1",
                     out_valid, p, terms, ovf, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_preadd();
        int n;
        bit found;
        found = 0;
        n = 0;
        send(3, 2, 5, 0, 3'b001, 1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || n != 4) begin
            errors++;
            $display("FAIL preadd_latency: got %0d cycles, required 4", n);
        end
        checks++;
        if (p !== 32'sd21 || terms !== 10'd1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL preadd_result: got P=%0d TERMS=%0d OVF=%0b, required P=21 TERMS=1 OVF=0", p, terms, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_presub_bias();
        bit found;
        found = 0;
        send(-4, 7, 2, 100, 3'b111, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || p !== 32'sd120 || terms !== 10'd1) begin
            errors++;
            $display("FAIL presub_bias: got P=%0d TERMS=%0d, required P=120 TERMS=1", p, terms);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        time t0;
        bit found;
        found = 0;
        t0 = $time;
        for (int i = 1; i <= 4; i++) send(i, i, 0, 0, 3'b000, i == 4);
        send(10, 10, 0, 0, 3'b000, 1);
        checks++;
        if ($time - t0 != 50) begin
            errors++;
            $display("FAIL b2b_no_bubble: got %0t time for 5 terms, required 50", $time - t0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || p !== 32'sd30 || terms !== 10'd4) begin
            errors++;
            $display("FAIL b2b_first: got P=%0d TERMS=%0d, required P=30 TERMS=4", p, terms);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || p !== 32'sd100 || terms !== 10'd1) begin
            errors++;
            $display("FAIL b2b_second: got OV=%0b P=%0d TERMS=%0d, required OV=1 P=100 TERMS=1", out_valid, p, terms);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_sat();
        longint av[3] = '{3, 16, -16};
        longint bv[3] = '{8, 2047, 2047};
        longint ep[3] = '{2, 127, -128};
        bit     eo[3] = '{0, 1, 1};
        for (int k = 0; k < 3; k++) begin
            bit found;
            found = 0;
            send(av[k], bv[k], 0, 0, 3'b000, 1);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (out_valid8) begin
                    found = 1;
                    break;
                end
            end
            checks++;
            if (!found || longint'(p8) !== ep[k] || ovf8 !== eo[k]) begin
                errors++;
                $display("FAIL round_sat_%0d: got P=%0d OVF=%0b, required P=%0d OVF=%0b", k, p8, ovf8, ep[k], eo[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] hold;
        bit found;
        found = 0;
        out_ready = 1'b0;
        send(5, 6, 0, 0, 3'b000, 1);
        send(7, 8, 0, 0, 3'b000, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || in_ready !== 1'b0 || p !== 32'sd30) begin
            errors++;
            $display("FAIL bp_first: got OV=%0b IR=%0b P=%0d, required OV=1 IR=0 P=30", out_valid, in_ready, p);
        end
        hold = p;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (p !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got P=%0d OV=%0b IR=%0b, required P=%0d OV=1 IR=0", p, out_valid, in_ready, hold);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (p !== 32'sd30 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_first: got P=%0d OV=%0b, required P=30 OV=1", p, out_valid);
        end
        @(negedge clk);
        checks++;
        if (p !== 32'sd56 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_second: got P=%0d OV=%0b, required P=56 OV=1", p, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        send(3, 3, 0, 0, 3'b000, 0);
        send(4, 4, 0, 0, 3'b000, 0);
        #2;
        rst_n = 1'b0;
        m_first = 1;
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== 32'sd0 || terms !== 10'd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got OV=%0b P=%0d TERMS=%0d OVF=%0b IR=%0b, required 0 0 0 0 1",
                     out_valid, p, terms, ovf, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 2, 0, 0, 3'b000, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || p !== 32'sd4 || terms !== 10'd1) begin
            errors++;
            $display("FAIL reset_new_frame: got P=%0d TERMS=%0d, required P=4 TERMS=1", p, terms);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_sat();
        bit found;
        found = 0;
        for (int i = 0; i < 1030; i++) send(1, 1, 0, 0, 3'b000, i == 1029);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || p !== 32'sd1030 || terms !== 10'd1023) begin
            errors++;
            $display("FAIL count_sat: got P=%0d TERMS=%0d, required P=1030 TERMS=1023", p, terms);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int t = 0; t < len; t++) begin
                longint av, bv, dv, cv;
                av = longint'($urandom_range(0, 262143)) - 131072;
                bv = longint'($urandom_range(0, 262143)) - 131072;
                dv = longint'($urandom_range(0, 262143)) - 131072;
                case ($urandom_range(0, 3))
                    0:       cv = ACC_MAX;
                    1:       cv = ACC_MIN;
                    default: cv = longint'($urandom_range(0, 2000)) - 1000;
                endcase
                if ($urandom_range(0, 1) == 0) av = longint'($urandom_range(0, 40)) - 20;
                send(av, bv, dv, cv, 3'($urandom_range(0, 7)), t == len - 1);
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (q0.size() == 0 && q8.size() == 0) break;
        end
        #1;
        checks++;
        if (q0.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d/%0d results outstanding, required 0/0", q0.size(), q8.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; d = '0; c = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_preadd();
        test_presub_bias();
        test_back_to_back();
        test_round_sat();
        test_backpressure();
        test_async_reset();
        test_count_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
